// File: rtl/qvga_fb_line_reader.sv
// qvga_fb_line_reader: fetches one QVGA source line per line_req from a
// synchronous-read frame buffer and streams it as registered RGB444 pixels
// to the 2x bilinear upscaler.
// Ports:
//   vga_clk, reset_n        pixel clock, async active-low reset
//   enable                  upscale mode; low parks the reader in IDLE
//   frame_start, line_req   1-cycle pulses: restart frame / fetch next line
//   fb_rd_en, fb_rd_addr    frame-buffer read strobe and row-major address
//   fb_rd_data              read data, valid RD_LAT cycles after fb_rd_en
//   base_data/valid/sol/eof pixel stream with start-of-line / end-of-frame tags
//   busy, overrun           burst or reads in flight / sticky dropped request
module qvga_fb_line_reader #(
  parameter int unsigned H_PIX   = 320,
  parameter int unsigned V_LINES = 240,
  parameter int unsigned DATA_W  = 12,
  parameter int unsigned ADDR_W  = 17,
  parameter int unsigned RD_LAT  = 1
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              frame_start,
  input  logic              line_req,
  output logic              fb_rd_en,
  output logic [ADDR_W-1:0] fb_rd_addr,
  input  logic [DATA_W-1:0] fb_rd_data,
  output logic [DATA_W-1:0] base_data,
  output logic              base_valid,
  output logic              base_sol,
  output logic              base_eof,
  output logic              busy,
  output logic              overrun
);

  localparam int unsigned X_W = $clog2(H_PIX);
  localparam int unsigned L_W = $clog2(V_LINES);

  typedef enum logic [1:0] {IDLE, READY, BURST, FRAME_DONE} state_t;

  state_t              state, state_n;
  logic [X_W-1:0]      x, x_n;
  logic [L_W-1:0]      line, line_n;
  logic [ADDR_W-1:0]   line_base, line_base_n;
  logic [ADDR_W-1:0]   fb_rd_addr_n;
  logic                pending, pending_n;
  logic                overrun_n;
  logic                fb_rd_en_n;
  logic                busy_n;
  logic [RD_LAT-1:0]   pipe_v, pipe_v_n;
  logic [RD_LAT-1:0]   pipe_sol, pipe_sol_n;
  logic [RD_LAT-1:0]   pipe_eof, pipe_eof_n;
  logic [DATA_W-1:0]   base_data_n;
  logic                base_valid_n, base_sol_n, base_eof_n;

  logic last_rd, last_line, flush;

  assign last_rd   = (state == BURST) && (x == X_W'(H_PIX - 1));
  assign last_line = (line == L_W'(V_LINES - 1));

  // State and datapath registers
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      x          <= '0;
      line       <= '0;
      line_base  <= '0;
      fb_rd_addr <= '0;
      pending    <= 1'b0;
      overrun    <= 1'b0;
      fb_rd_en   <= 1'b0;
      busy       <= 1'b0;
      pipe_v     <= '0;
      pipe_sol   <= '0;
      pipe_eof   <= '0;
      base_data  <= '0;
      base_valid <= 1'b0;
      base_sol   <= 1'b0;
      base_eof   <= 1'b0;
    end else begin
      state      <= state_n;
      x          <= x_n;
      line       <= line_n;
      line_base  <= line_base_n;
      fb_rd_addr <= fb_rd_addr_n;
      pending    <= pending_n;
      overrun    <= overrun_n;
      fb_rd_en   <= fb_rd_en_n;
      busy       <= busy_n;
      pipe_v     <= pipe_v_n;
      pipe_sol   <= pipe_sol_n;
      pipe_eof   <= pipe_eof_n;
      base_data  <= base_data_n;
      base_valid <= base_valid_n;
      base_sol   <= base_sol_n;
      base_eof   <= base_eof_n;
    end
  end

  // Next-state logic; enable and frame_start override the current state
  always_comb begin
    state_n = state;
    if (!enable) begin
      state_n = IDLE;
    end else if (frame_start) begin
      state_n = line_req ? BURST : READY;
    end else begin
      case (state)
        READY: if (line_req) state_n = BURST;
        BURST: begin
          if (last_rd) begin
            if (last_line)                state_n = FRAME_DONE;
            else if (pending || line_req) state_n = BURST;
            else                          state_n = READY;
          end
        end
        default: state_n = state;
      endcase
    end
  end

  // Counters, request bookkeeping and the read-tag pipeline
  always_comb begin
    x_n          = x;
    line_n       = line;
    line_base_n  = line_base;
    fb_rd_addr_n = fb_rd_addr;
    pending_n    = pending;
    overrun_n    = overrun;
    flush        = 1'b0;

    if (!enable) begin
      pending_n = 1'b0;
      flush     = 1'b1;
    end else if (frame_start) begin
      x_n          = '0;
      line_n       = '0;
      line_base_n  = '0;
      fb_rd_addr_n = '0;
      pending_n    = 1'b0;
      overrun_n    = 1'b0;
      flush        = 1'b1;
    end else begin
      case (state)
        READY: if (line_req) fb_rd_addr_n = line_base;
        BURST: begin
          // One-deep request queue; a request arriving while it is full is lost
          if (line_req) begin
            if (pending) overrun_n = 1'b1;
            else         pending_n = 1'b1;
          end
          if (last_rd) begin
            x_n       = '0;
            pending_n = 1'b0;
            if (!last_line) begin
              line_n       = line + L_W'(1);
              line_base_n  = line_base + ADDR_W'(H_PIX);
              fb_rd_addr_n = line_base + ADDR_W'(H_PIX);
            end
          end else begin
            x_n          = x + X_W'(1);
            fb_rd_addr_n = fb_rd_addr + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end

    // Tags travel alongside the read so they meet fb_rd_data after RD_LAT cycles
    pipe_v_n      = '0;
    pipe_sol_n    = '0;
    pipe_eof_n    = '0;
    if (!flush) begin
      pipe_v_n[0]   = fb_rd_en;
      pipe_sol_n[0] = fb_rd_en && (x == '0);
      pipe_eof_n[0] = last_rd && last_line;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        pipe_v_n[i]   = pipe_v[i-1];
        pipe_sol_n[i] = pipe_sol[i-1];
        pipe_eof_n[i] = pipe_eof[i-1];
      end
    end
  end

  // Registered output values
  always_comb begin
    fb_rd_en_n   = (state_n == BURST);
    busy_n       = (state_n == BURST) || (|pipe_v_n);
    base_data_n  = base_data;
    base_valid_n = 1'b0;
    base_sol_n   = 1'b0;
    base_eof_n   = 1'b0;
    if (!flush && pipe_v[RD_LAT-1]) begin
      base_data_n  = fb_rd_data;
      base_valid_n = 1'b1;
      base_sol_n   = pipe_sol[RD_LAT-1];
      base_eof_n   = pipe_eof[RD_LAT-1];
    end
  end

endmodule

// File: tb/tb_qvga_fb_line_reader.sv
// Directed bench for qvga_fb_line_reader: expected reads and pixels (with the
// cycle they must appear on) are queued when requests are issued; monitors
// pop and compare on every fb_rd_en / base_valid cycle.
module tb_qvga_fb_line_reader;

  localparam int unsigned H_PIX   = 320;
  localparam int unsigned V_LINES = 240;
  localparam int unsigned DATA_W  = 12;
  localparam int unsigned ADDR_W  = 17;
  localparam int unsigned RD_LAT  = 1;

  logic              vga_clk = 1'b0;
  logic              reset_n;
  logic              enable, frame_start, line_req;
  logic              fb_rd_en;
  logic [ADDR_W-1:0] fb_rd_addr;
  logic [DATA_W-1:0] fb_rd_data;
  logic [DATA_W-1:0] base_data;
  logic              base_valid, base_sol, base_eof, busy, overrun;

  qvga_fb_line_reader #(
    .H_PIX(H_PIX), .V_LINES(V_LINES), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)
  ) dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .enable(enable), .frame_start(frame_start),
    .line_req(line_req), .fb_rd_en(fb_rd_en), .fb_rd_addr(fb_rd_addr), .fb_rd_data(fb_rd_data),
    .base_data(base_data), .base_valid(base_valid), .base_sol(base_sol), .base_eof(base_eof),
    .busy(busy), .overrun(overrun)
  );

  always #5 vga_clk = ~vga_clk;

  int cyc = 0;
  always @(posedge vga_clk) cyc <= cyc + 1;

  // Frame-buffer model: contents are a fixed function of the address
  function automatic logic [DATA_W-1:0] fb_pix(input int a);
    int v;
    v = a * 5 + (a >>> 9) + 7;
    return DATA_W'(v);
  endfunction

  logic [DATA_W-1:0] rd_pipe [RD_LAT];
  always @(posedge vga_clk) begin
    rd_pipe[0] <= fb_rd_en ? fb_pix(int'(fb_rd_addr)) : '0;
    for (int i = 1; i < int'(RD_LAT); i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign fb_rd_data = rd_pipe[RD_LAT-1];

  typedef struct { int addr; int cyc; } rd_exp_t;
  typedef struct { logic [DATA_W-1:0] data; logic sol; logic eof; int cyc; } px_exp_t;

  rd_exp_t rdq[$];
  px_exp_t pxq[$];
  int vectors = 0;
  int miscompares = 0;
  int rd_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_line(input int ln, input int start, input int nread, input int npix);
    int base;
    base = ln * int'(H_PIX);
    for (int i = 0; i < nread; i++) rdq.push_back('{addr: base + i, cyc: start + i});
    for (int i = 0; i < npix; i++)
      pxq.push_back('{data: fb_pix(base + i), sol: (i == 0),
                      eof: (ln == int'(V_LINES) - 1 && i == int'(H_PIX) - 1),
                      cyc: start + 1 + int'(RD_LAT) + i});
  endtask

  // Read-side monitor
  always @(negedge vga_clk) begin
    if (reset_n && fb_rd_en) begin
      rd_exp_t e;
      rd_seen++;
      if (rdq.size() == 0) begin
        check("unexpected_read", 64'(fb_rd_addr), 64'hFFFF_FFFF);
      end else begin
        e = rdq.pop_front();
        check("read_addr_cycle", {32'(fb_rd_addr), 32'(cyc)}, {32'(e.addr), 32'(e.cyc)});
      end
    end
  end

  // Pixel-side monitor
  always @(negedge vga_clk) begin
    if (reset_n && base_valid) begin
      px_exp_t p;
      if (pxq.size() == 0) begin
        check("unexpected_pixel", 64'(base_data), 64'hFFFF_FFFF);
      end else begin
        p = pxq.pop_front();
        check("pixel_sol_eof_cycle", {base_data, base_sol, base_eof, 32'(cyc)},
              {p.data, p.sol, p.eof, 32'(p.cyc)});
      end
    end
  end

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge vga_clk);
  endtask

  task automatic wait_drain(input int bound);
    int t;
    t = 0;
    while ((rdq.size() != 0 || pxq.size() != 0) && t < bound) begin
      @(negedge vga_clk);
      t++;
    end
    check("drain", 64'(rdq.size() + pxq.size()), 64'd0);
    @(negedge vga_clk);
  endtask

  // First request from READY, each later line requested mid-burst so bursts chain
  task automatic run_lines(input int first, input int count);
    int s;
    s = cyc + 1;
    line_req = 1'b1;
    push_line(first, s, int'(H_PIX), int'(H_PIX));
    @(negedge vga_clk);
    line_req = 1'b0;
    for (int k = 1; k < count; k++) begin
      wait_cyc(s + 100);
      line_req = 1'b1;
      s += int'(H_PIX);
      push_line(first + k, s, int'(H_PIX), int'(H_PIX));
      @(negedge vga_clk);
      line_req = 1'b0;
    end
    wait_drain(1000);
  endtask

  initial begin
    int s;
    int r0;
    reset_n = 1'b0; enable = 1'b0; frame_start = 1'b0; line_req = 1'b0;
    #3;
    check("reset_outputs", {fb_rd_en, base_valid, base_sol, base_eof, busy, overrun},
          6'b000000);
    check("reset_addr_data", {32'(fb_rd_addr), 32'(base_data)}, 64'd0);
    repeat (3) @(negedge vga_clk);
    reset_n = 1'b1;
    @(negedge vga_clk);
    enable = 1'b1;

    // Frame start and request together: line 0 starts next cycle
    s = cyc + 1;
    frame_start = 1'b1; line_req = 1'b1;
    push_line(0, s, int'(H_PIX), int'(H_PIX));
    @(negedge vga_clk);
    frame_start = 1'b0; line_req = 1'b0;
    check("busy_in_burst", 64'(busy), 64'd1);
    wait_drain(1000);
    check("idle_after_line0", {busy, overrun, fb_rd_en}, 3'b000);

    // Lines 1 and 2 back to back via a pending request
    run_lines(1, 2);
    check("overrun_after_pending", 64'(overrun), 64'd0);

    // Three requests in one burst: third is dropped
    s = cyc + 1;
    line_req = 1'b1;
    push_line(3, s, int'(H_PIX), int'(H_PIX));
    @(negedge vga_clk);
    line_req = 1'b0;
    wait_cyc(s + 10);
    line_req = 1'b1;
    push_line(4, s + int'(H_PIX), int'(H_PIX), int'(H_PIX));
    @(negedge vga_clk);
    line_req = 1'b0;
    wait_cyc(s + 20);
    line_req = 1'b1;
    @(negedge vga_clk);
    line_req = 1'b0;
    check("overrun_set", 64'(overrun), 64'd1);
    wait_drain(1200);
    check("overrun_sticky", 64'(overrun), 64'd1);

    // Line 5 aborted by frame_start while x=100 is being read
    s = cyc + 1;
    line_req = 1'b1;
    push_line(5, s, 101, 100 - int'(RD_LAT));
    @(negedge vga_clk);
    line_req = 1'b0;
    wait_cyc(s + 100);
    frame_start = 1'b1;
    @(negedge vga_clk);
    frame_start = 1'b0;
    check("abort_rd_en_low", {fb_rd_en, base_valid}, 2'b00);
    check("overrun_cleared", 64'(overrun), 64'd0);
    repeat (5) @(negedge vga_clk);
    wait_drain(50);
    check("abort_idle", 64'(busy), 64'd0);

    // Full frame from address 0 through line 239
    run_lines(0, int'(V_LINES));
    check("frame_done_idle", {busy, overrun}, 2'b00);

    // Request in FRAME_DONE: no reads, no overrun
    r0 = rd_seen;
    line_req = 1'b1;
    @(negedge vga_clk);
    line_req = 1'b0;
    repeat (8) @(negedge vga_clk);
    check("no_reads_after_frame", 64'(rd_seen - r0), 64'd0);
    check("no_overrun_in_frame_done", {overrun, busy}, 2'b00);

    // Async reset mid-burst clears outputs without a clock edge
    s = cyc + 1;
    frame_start = 1'b1; line_req = 1'b1;
    push_line(0, s, int'(H_PIX), int'(H_PIX));
    @(negedge vga_clk);
    frame_start = 1'b0; line_req = 1'b0;
    wait_cyc(s + 5);
    check("pre_reset_active", {fb_rd_en, base_valid}, 2'b11);
    #1 reset_n = 1'b0;
    #1;
    check("async_reset_clear", {fb_rd_en, base_valid, busy}, 3'b000);
    rdq.delete();
    pxq.delete();
    repeat (2) @(negedge vga_clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
